// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, default data width
// and parity-type constants, common to the transmitter and receiver.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// UART transmit parity generator: XOR of the data for even parity,
// XNOR for odd parity, so data plus parity carries the chosen count.
module uart_tx_parity_gen
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   always_comb begin
      par_bit = (par_typ == ODD) ? ~(^data) : ^data;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Define UART_TX_PRESCALE_EN to stretch each bit to Prescale clocks.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
`ifdef UART_TX_PRESCALE_EN
   input  logic [5:0]            Prescale,
`endif
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   uart_state_t           state;
   uart_state_t           state_nx;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_nx;
   logic [CW-1:0]         bcnt;
   logic [CW-1:0]         bcnt_nx;
   logic                  par_en_q;
   logic                  par_q;
   logic                  par_bit;
   logic                  accept;
   logic                  tick;
   logic                  tx_d;
   logic                  busy_d;

   assign accept = (state == IDLE) && Data_Valid;

   uart_tx_parity_gen #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_parity_gen (
      .data   (P_DATA),
      .par_typ(PAR_TYP),
      .par_bit(par_bit)
   );

`ifdef UART_TX_PRESCALE_EN
   logic [5:0] pcnt;
   logic [5:0] pre_q;

   assign tick = (pcnt == pre_q - 6'd1);

   // Prescale of 0 or 1 both mean one clock per bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt  <= 6'd0;
         pre_q <= 6'd1;
      end else if (accept) begin
         pcnt  <= 6'd0;
         pre_q <= (Prescale > 6'd1) ? Prescale : 6'd1;
      end else if (state == IDLE || tick) begin
         pcnt  <= 6'd0;
      end else begin
         pcnt  <= pcnt + 6'd1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      bcnt_nx  = bcnt;
      unique case (state)
         IDLE: begin
            if (Data_Valid) begin
               state_nx = START;
               shreg_nx = P_DATA;
               bcnt_nx  = '0;
            end
         end
         START: begin
            if (tick) state_nx = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_nx = shreg >> 1;
               if (bcnt == LAST) begin
                  bcnt_nx  = '0;
                  state_nx = par_en_q ? PARITY : STOP;
               end else begin
                  bcnt_nx  = bcnt + CW'(1);
               end
            end
         end
         PARITY: begin
            if (tick) state_nx = STOP;
         end
         STOP: begin
            if (tick) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Decoded from the next state so TX_OUT lines up with the state
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_nx != IDLE);
      unique case (state_nx)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_nx[0];
         PARITY:  tx_d = par_q;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         bcnt     <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         TX_OUT   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         shreg  <= shreg_nx;
         bcnt   <= bcnt_nx;
         TX_OUT <= tx_d;
         busy   <= busy_d;
         if (accept) begin
            par_en_q <= PAR_EN;
            par_q    <= par_bit;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames, scoreboard queue of expected
// per-bit strings, monitor that rebuilds each frame from TX_OUT.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
`ifdef UART_TX_PRESCALE_EN
   logic [5:0] Prescale;
`endif
   logic       TX_OUT;
   logic       busy;

   int    n_chk  = 0;
   int    n_fail = 0;
   string exp_q[$];
   int    ps_q[$];
   int    cur_ps = 1;
   bit    abort  = 1'b0;
   bit    busy_p = 1'b0;
   string cap    = "";
   string e;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .P_DATA    (P_DATA),
      .Data_Valid(Data_Valid),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
`ifdef UART_TX_PRESCALE_EN
      .Prescale  (Prescale),
`endif
      .TX_OUT    (TX_OUT),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic string expand(input string s, input int ps);
      string r = "";
      for (int i = 0; i < s.len(); i++)
         for (int j = 0; j < ps; j++)
            r = $sformatf("%s%s", r, s.substr(i, i));
      return r;
   endfunction

   // Monitor: one character per clock while busy, compared at frame end
   always @(negedge clk) begin
      if (busy === 1'b1) begin
         cap = $sformatf("%s%0b", cap, TX_OUT);
      end else if (busy_p) begin
         if (abort) begin
            abort = 1'b0;
         end else if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got %s expected none", cap);
         end else begin
            e = expand(exp_q.pop_front(), ps_q.pop_front());
            check("frame_len", cap.len(), e.len());
            n_chk++;
            if (cap != e) begin
               n_fail++;
               $display("FAIL frame_bits: got %s expected %s", cap, e);
            end
         end
         cap = "";
      end
      busy_p = (busy === 1'b1);
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                       input bit push, input string exp);
      @(negedge clk);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         ps_q.push_back(cur_ps);
      end
      @(negedge clk);
      Data_Valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) check(name, busy, 0);
   endtask

   initial begin
      int gap;
      rst        = 1'b1;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
`ifdef UART_TX_PRESCALE_EN
      Prescale   = 6'd1;
`endif
      repeat (2) @(negedge clk);
      check("reset_tx", TX_OUT, 1);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_tx", TX_OUT, 1);

      send(8'hA5, 1'b1, 1'b0, 1'b1, "01010010101");
      wait_idle("timeout_a5_even");

      send(8'hA5, 1'b1, 1'b1, 1'b1, "01010010111");
      P_DATA  = 8'h00;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      wait_idle("timeout_a5_odd");

      send(8'h07, 1'b1, 1'b0, 1'b1, "01110000011");
      wait_idle("timeout_07");

      send(8'hFF, 1'b0, 1'b0, 1'b1, "0111111111");
      wait_idle("timeout_ff");

      send(8'hA5, 1'b1, 1'b0, 1'b1, "01010010101");
      repeat (3) @(negedge clk);
      P_DATA     = 8'h3C;
      Data_Valid = 1'b1;
      @(negedge clk);
      Data_Valid = 1'b0;
      wait_idle("timeout_ignore");
      repeat (20) @(negedge clk);

      // Held request: back-to-back frames with a single idle clock
      @(negedge clk);
      P_DATA     = 8'h81;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      exp_q.push_back("0100000011");
      ps_q.push_back(cur_ps);
      exp_q.push_back("0100000011");
      ps_q.push_back(cur_ps);
      @(negedge clk);
      wait_idle("timeout_hold1");
      gap = 0;
      while (busy !== 1'b1 && gap < 20) begin
         gap++;
         @(negedge clk);
      end
      check("idle_gap", gap, 1);
      Data_Valid = 1'b0;
      wait_idle("timeout_hold2");

      send(8'hA5, 1'b1, 1'b0, 1'b0, "");
      repeat (4) @(negedge clk);
      check("bit3_before_rst", TX_OUT, 0);
      abort = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("abort_tx", TX_OUT, 1);
      check("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h5A, 1'b1, 1'b0, 1'b1, "00101101001");
      wait_idle("timeout_5a");

`ifdef UART_TX_PRESCALE_EN
      cur_ps   = 8;
      Prescale = 6'd8;
      send(8'hA5, 1'b1, 1'b0, 1'b1, "01010010101");
      repeat (5) @(negedge clk);
      Prescale = 6'd3;
      wait_idle("timeout_prescale");
`endif

      repeat (30) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
